// File: rtl/if_fetch_if.sv
// Port bundle for the instruction-fetch stage: ID-side control, ROM bus and IF/ID outputs.
// master = fetch stage, slave = surrounding pipeline / ROM.
interface if_fetch_if;
    logic        stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic [31:0] rom_inst;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;

    modport master (
        input  stall, flush, new_pc, branch_flag, branch_target, rom_inst,
        output rom_ce, rom_addr, id_pc, id_inst, id_valid
    );

    modport slave (
        output stall, flush, new_pc, branch_flag, branch_target, rom_inst,
        input  rom_ce, rom_addr, id_pc, id_inst, id_valid
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, ROM enable/address and IF/ID register with stall/branch/flush.
// Define IF_PERF_CNT_EN to add fetch_cnt / stall_cnt performance counters.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic         clk,
    input  logic         rst,
    if_fetch_if.master   bus
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]  fetch_cnt,
    output logic [31:0]  stall_cnt
`endif
);

    typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

    state_t      state, state_nx;
    logic        ce, ce_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] id_pc_q, id_pc_nx;
    logic [31:0] id_inst_q, id_inst_nx;
    logic        id_valid_q, id_valid_nx;
    logic        load_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BOOT;
            ce         <= 1'b0;
            pc         <= RESET_PC;
            id_pc_q    <= '0;
            id_inst_q  <= '0;
            id_valid_q <= 1'b0;
        end else begin
            state      <= state_nx;
            ce         <= ce_nx;
            pc         <= pc_nx;
            id_pc_q    <= id_pc_nx;
            id_inst_q  <= id_inst_nx;
            id_valid_q <= id_valid_nx;
        end
    end

    // Priority in RUN: flush > stall > branch > sequential. The instruction
    // fetched alongside a taken branch is its delay slot and is kept.
    always_comb begin
        state_nx    = state;
        ce_nx       = ce;
        pc_nx       = pc;
        id_pc_nx    = id_pc_q;
        id_inst_nx  = id_inst_q;
        id_valid_nx = id_valid_q;
        load_en     = 1'b0;
        case (state)
            BOOT: begin
                state_nx    = RUN;
                ce_nx       = 1'b1;
                id_pc_nx    = '0;
                id_inst_nx  = '0;
                id_valid_nx = 1'b0;
                if (bus.flush)
                    pc_nx = bus.new_pc;
            end
            RUN: begin
                if (bus.flush) begin
                    pc_nx       = bus.new_pc;
                    id_pc_nx    = '0;
                    id_inst_nx  = '0;
                    id_valid_nx = 1'b0;
                end else if (!bus.stall) begin
                    load_en     = 1'b1;
                    id_pc_nx    = pc;
                    id_inst_nx  = bus.rom_inst;
                    id_valid_nx = 1'b1;
                    pc_nx       = bus.branch_flag ? bus.branch_target : pc + 32'(PC_STEP);
                end
            end
            default: begin
                state_nx = BOOT;
                ce_nx    = 1'b0;
            end
        endcase
    end

    assign bus.rom_ce   = ce;
    assign bus.rom_addr = pc;
    assign bus.id_pc    = id_pc_q;
    assign bus.id_inst  = id_inst_q;
    assign bus.id_valid = id_valid_q;

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else if (state == RUN) begin
            if (load_en)
                fetch_cnt <= fetch_cnt + 32'd1;
            if (bus.stall && !bus.flush)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: driver steps a behavioural model and queues the expected
// post-edge state; a monitor pops and compares after every edge.
module tb_if_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned PC_STEP  = 4;

    logic clk;
    logic rst;
    if_fetch_if bus();

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt, stall_cnt;
`endif

    if_fetch #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt (fetch_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000_0000 + {23'd0, a[10:2]};
    endfunction

    assign bus.rom_inst = bus.rom_ce ? rom_word(bus.rom_addr) : 32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    typedef struct {
        logic        ce;
        logic [31:0] addr;
        logic [31:0] id_pc;
        logic [31:0] inst;
        logic        vld;
        logic [31:0] fc;
        logic [31:0] sc;
    } exp_t;
    exp_t q[$];

    // Reference model: architectural view of the fetch stage
    bit          m_run;
    logic [31:0] m_pc, m_idpc, m_inst;
    logic        m_vld;
    logic [31:0] m_fc, m_sc;

    task automatic model_reset();
        m_run = 0; m_pc = RESET_PC; m_idpc = 0; m_inst = 0; m_vld = 0; m_fc = 0; m_sc = 0;
    endtask

    task automatic cmp_state(input string tag, input exp_t e);
        chk({tag, ".rom_ce"},   {31'd0, bus.rom_ce},   {31'd0, e.ce});
        chk({tag, ".rom_addr"}, bus.rom_addr,          e.addr);
        chk({tag, ".id_pc"},    bus.id_pc,             e.id_pc);
        chk({tag, ".id_inst"},  bus.id_inst,           e.inst);
        chk({tag, ".id_valid"}, {31'd0, bus.id_valid}, {31'd0, e.vld});
`ifdef IF_PERF_CNT_EN
        chk({tag, ".fetch_cnt"}, fetch_cnt, e.fc);
        chk({tag, ".stall_cnt"}, stall_cnt, e.sc);
`endif
    endtask

    // Called at a negedge: drive inputs, predict the next edge, wait for the following negedge.
    task automatic cyc(input bit s, input bit f, input logic [31:0] np, input bit b, input logic [31:0] bt);
        exp_t e;
        bus.stall = s; bus.flush = f; bus.new_pc = np; bus.branch_flag = b; bus.branch_target = bt;
        if (!m_run) begin
            m_run = 1;
            if (f) m_pc = np;
        end else if (f) begin
            m_pc = np; m_idpc = 0; m_inst = 0; m_vld = 0;
        end else if (s) begin
            m_sc = m_sc + 1;
        end else begin
            m_idpc = m_pc; m_inst = rom_word(m_pc); m_vld = 1; m_fc = m_fc + 1;
            m_pc = b ? bt : m_pc + PC_STEP;
        end
        e = '{ce: m_run, addr: m_pc, id_pc: m_idpc, inst: m_inst, vld: m_vld, fc: m_fc, sc: m_sc};
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic seq(); cyc(0, 0, 0, 0, 0); endtask

    // Reset asserted between edges must take effect without a clock.
    task automatic async_reset();
        exp_t e;
        rst = 1'b1;
        #1;
        model_reset();
        e = '{ce: 0, addr: RESET_PC, id_pc: 0, inst: 0, vld: 0, fc: 0, sc: 0};
        cmp_state("async_rst", e);
        @(negedge clk);
        rst = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() != 0) cmp_state("edge", q.pop_front());
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e0;
        bus.stall = 0; bus.flush = 0; bus.new_pc = 0; bus.branch_flag = 0; bus.branch_target = 0;
        rst = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        #2;
        e0 = '{ce: 0, addr: RESET_PC, id_pc: 0, inst: 0, vld: 0, fc: 0, sc: 0};
        cmp_state("reset", e0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed: boot, sequential, stall, branch delay slot, flush priority, wrap
        seq(); seq(); seq();
        cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 1, 32'h100); cyc(1, 0, 0, 0, 0);
        seq();
        cyc(0, 0, 0, 1, 32'h40);
        seq(); seq();
        cyc(1, 1, 32'h180, 1, 32'h20);
        seq();
        cyc(0, 1, 32'hFFFF_FFFC, 0, 0);
        seq(); seq();
        cyc(1, 0, 0, 0, 0);
        async_reset();
        // Flush during BOOT still redirects; stall/branch ignored there
        cyc(1, 1, 32'h200, 1, 32'h300);
        seq(); seq();

        // Random phase
        for (int i = 0; i < 400; i++) begin
            int unsigned r;
            logic [31:0] np, bt;
            r  = $urandom_range(0, 99);
            np = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            bt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : $urandom;
            if (r < 2) async_reset();
            else cyc($urandom_range(0, 4) == 0, $urandom_range(0, 14) == 0, np,
                     $urandom_range(0, 3) == 0, bt);
        end

        repeat (2) @(negedge clk);
        chk("drain", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage directly upstream of the instruction ROM.
- Owns the program counter and drives the ROM chip-enable and address.
- Captures the ROM's combinational instruction word into the IF/ID pipeline register.
- Handles pipeline stall, branch redirect (MIPS delay-slot semantics) and exception flush.

Parameters:
RESET_PC  32'h0000_0000  PC value loaded on reset; first address fetched.
PC_STEP  4  byte increment per sequential fetch.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
stall  input  1  hold PC and IF/ID register this cycle.
flush  input  1  redirect to new_pc and insert bubble.
new_pc  input  32  exception/flush target PC.
branch_flag  input  1  branch taken, decided in ID.
branch_target  input  32  branch destination PC.
rom_inst  input  32  instruction word from ROM, valid same cycle as rom_addr.
rom_ce  output  1  ROM chip enable; ROM returns 0 when low.
rom_addr  output  32  byte address to ROM; ROM indexes with addr[10:2].
id_pc  output  32  PC of the instruction held in IF/ID.
id_inst  output  32  instruction held in IF/ID.
id_valid  output  1  IF/ID holds a real instruction, not a bubble.

Behaviour:
- Registers: pc, ce, state, id_pc, id_inst, id_valid. rom_addr = pc; rom_ce = ce (no combinational paths from inputs).
- Reset (async, any time, including mid-stall or mid-redirect):
  - pc=RESET_PC, ce=0, state=BOOT.
  - id_pc=0, id_inst=0, id_valid=0.
- FSM has two states.
- BOOT:
  - ce=0 and pc is held.
  - Next edge: ce<=1, state<=RUN.
  - stall and branch_flag are ignored in BOOT.
  - flush in BOOT loads pc<=new_pc and still moves to RUN.
  - IF/ID stays a bubble (id_valid=0, id_inst=0).
- RUN: per rising edge, priority flush > stall > branch > sequential.
  - flush: pc<=new_pc; id_inst<=0, id_pc<=0, id_valid<=0. Same cycle's stall/branch ignored.
  - stall (no flush): pc, id_pc, id_inst, id_valid all hold. A branch_flag asserted during stall is dropped; ID must re-present it after stall releases.
  - branch_flag: pc<=branch_target; id_pc<=pc, id_inst<=rom_inst, id_valid<=1. The instruction fetched this cycle is the delay slot and is kept.
  - otherwise: pc<=pc+PC_STEP; id_pc<=pc, id_inst<=rom_inst, id_valid<=1.
- Arithmetic:
  - pc+PC_STEP is 32-bit modulo; 32'hFFFF_FFFC advances to 32'h0000_0000.
  - No alignment check; targets are used as given.
- Latency:
  - Instruction at address A appears on id_inst one edge after A is presented on rom_addr with no stall.
  - First valid IF/ID appears on the 2nd edge after reset release.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- When defined, adds two ports:
  - fetch_cnt  output  32: increments on every RUN edge where IF/ID loads with id_valid<=1.
  - stall_cnt  output  32: increments on every RUN edge where stall=1 and flush=0.
- Both counters reset to 0 on rst and wrap modulo 2^32.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then release, ROM word k = 32'h1000_0000+k:
  - edge1: rom_ce=1, rom_addr=0, id_valid=0.
  - edge2: id_pc=0, id_inst=32'h1000_0000, id_valid=1, rom_addr=4.
- Sequential run of 5 edges -> id_pc steps 0,4,8,12,16 with matching id_inst; rom_addr leads id_pc by 4.
- stall high 3 cycles at rom_addr=8 -> rom_addr stays 8 and id_pc=4/id_inst held for 3 cycles; resumes id_pc=8 on the first edge after release.
- branch_flag=1, branch_target=32'h40 at rom_addr=12:
  - next edge: id_pc=12 (delay slot, valid), rom_addr=32'h40.
  - following edge: id_pc=32'h40.
- flush=1 with stall=1 and branch_flag=1, new_pc=32'h180 -> next edge: rom_addr=32'h180, id_valid=0, id_inst=0.
- Wrap and reset:
  - Flush to new_pc=32'hFFFF_FFFC, run 2 edges -> rom_addr=0, id_pc=32'hFFFF_FFFC.
  - Assert rst between edges -> outputs return to reset values immediately, without waiting for a clock edge.
